window_3x3_gen: RTL
===================

Name: window_3x3_gen

Overview:
- Builds a 3x3 pixel neighbourhood from a raster-order pixel stream for the convolution stages of the Gaussian/DoG pyramid.
- Holds two image-row delay lines, which are stall-able word-wide shift registers of depth IMG_W, plus a 3-column window register.
- Presents each complete interior window with its centre coordinate.
- Sits directly downstream of the pixel delay/shift stage and feeds the Gaussian kernel multiplier array.

Parameters:
- DATA_W, 8, pixel width in bits
- IMG_W, 640, pixels per row (>= 3)
- IMG_H, 480, rows per frame (>= 3)
- XW, $clog2(IMG_W), column counter width (derived)
- YW, $clog2(IMG_H), row counter width (derived)

Ports:
- Clock  in  1  system clock; all state updates on the rising edge
- Rst  in  1  asynchronous, active-low reset
- Frame_Start  in  1  marks the current Data_In as pixel (0,0); qualified by Data_In_Valid
- Data_In  in  DATA_W  pixel value
- Data_In_Valid  in  1  pixel accepted on this edge when high
- Window_Out  out  9*DATA_W  window; element k=3*r+c at bits [k*DATA_W +: DATA_W]; r=0 is the oldest row (top), c=0 is the oldest column (left)
- Window_Valid  out  1  Window_Out holds a complete interior window
- Center_X  out  XW  column of the window centre
- Center_Y  out  YW  row of the window centre
- Frame_Done  out  1  one-cycle pulse: last pixel of the frame accepted

Behaviour:
- Reset (Rst low, async): state=IDLE; col/row counters=0; Window_Out=0; Window_Valid=0; Center_X=0; Center_Y=0; Frame_Done=0. Delay-line contents are don't-care.
- Accept = Data_In_Valid high on a rising edge. When Data_In_Valid is low, nothing shifts and no counter moves. Window_Out, Center_X and Center_Y hold. Window_Valid and Frame_Done are 0 on that cycle.
- FSM IDLE: accepts with Frame_Start=0 are dropped (no shift, no output). An accept with Frame_Start=1 processes that pixel as (0,0) and goes to ACTIVE.
- FSM ACTIVE: each accept processes pixel (col,row), then advances the counters.
  - col wraps IMG_W-1 -> 0 with row+1.
  - Accepting (IMG_W-1, IMG_H-1) returns the FSM to IDLE and asserts Frame_Done on the following cycle.
- Frame_Start=1 on an accept while ACTIVE restarts: that pixel is (0,0), the counters reload and the FSM stays ACTIVE. Stale delay-line data is harmless because validity is gated by row.
- Datapath on each processed pixel (col,row):
  - line1 receives Data_In; line1 output feeds line2.
  - The new column is {line2_out, line1_out, Data_In} (top to bottom).
  - The new column shifts into the c=2 position; the old c=2 moves to c=1 and the old c=1 moves to c=0.
- Output timing: registered, 1-cycle latency. On the cycle after processing (col,row):
  - Window_Valid = (row>=2 && col>=2).
  - Center_X = col-1; Center_Y = row-1.
- No border padding: windows straddling a row wrap (col<2) are never flagged valid.
- Valid windows per frame = (IMG_W-2)*(IMG_H-2).
- No downstream backpressure; the consumer must take one window per valid cycle.
- Simultaneous events: the last-pixel accept flags its own window valid and asserts Frame_Done in the same output cycle.

Test Plan (IMG_W=5, IMG_H=4, DATA_W=8, pixel (x,y) = 10*y+x, Data_In_Valid continuous unless stated):
- Full frame, Frame_Start with (0,0):
  - First Window_Valid comes 1 cycle after (2,2) is accepted, with Center=(1,1) and Window_Out = 0,1,2,10,11,12,20,21,22 (k=0..8).
  - Exactly 6 valid windows.
  - The last has Center=(3,2) and values 12,13,14,22,23,24,32,33,34, with Frame_Done high in the same cycle.
- Pixels without Frame_Start while IDLE (value 0xFF ×7), then a frame: no Window_Valid from the 0xFF pixels; the following frame's windows are identical to the full-frame case.
- Randomly deassert Data_In_Valid (~40%) across the frame: Window_Out values and Center sequence are identical to the continuous case; Window_Valid never asserts on a stall cycle.
- Frame_Start reasserted at pixel (3,2) mid-frame, then a full frame: no valid window until the new (2,2) has been accepted; that window equals 0,1,2,10,11,12,20,21,22; 6 valid windows and one Frame_Done.
- Rst pulsed low mid-frame, asynchronously between edges: all outputs are 0 immediately. With no Frame_Start, subsequent pixels produce nothing; a new frame then behaves as in the full-frame case.
- Back-to-back frames, the second starting the cycle after the first ends: Frame_Done pulses twice; the second frame's first window equals 0,1,2,10,11,12,20,21,22.

Source files
------------

// File: rtl/window_3x3_gen.sv
// rtl/window_3x3_gen.sv - 3x3 neighbourhood builder over a raster pixel stream
module window_3x3_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int XW     = $clog2(IMG_W),
  parameter int YW     = $clog2(IMG_H)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_frame_start,
  input  logic [DATA_W-1:0]     i_data_in,
  input  logic                  i_data_in_valid,
  output logic [9*DATA_W-1:0]   o_window_out,
  output logic                  o_window_valid,
  output logic [XW-1:0]         o_center_x,
  output logic [YW-1:0]         o_center_y,
  output logic                  o_frame_done
);

  typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

  state_t              r_state;
  state_t              w_next_state;

  logic [XW-1:0]       r_col;
  logic [YW-1:0]       r_row;

  logic                w_process;
  logic [XW-1:0]       w_col;
  logic [YW-1:0]       w_row;
  logic                w_col_last;
  logic                w_last;
  logic                w_win_ok;

  logic [DATA_W-1:0]   r_line1 [IMG_W];
  logic [DATA_W-1:0]   r_line2 [IMG_W];
  logic [DATA_W-1:0]   w_line1_out;
  logic [DATA_W-1:0]   w_line2_out;
  logic [DATA_W-1:0]   w_new_col [3];

  logic [DATA_W-1:0]   r_win [9];
  logic                r_window_valid;
  logic [XW-1:0]       r_center_x;
  logic [YW-1:0]       r_center_y;
  logic                r_frame_done;

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state: a processed pixel keeps us ACTIVE unless it closes the frame
  always_comb begin
    w_next_state = r_state;
    if (w_process) begin
      w_next_state = w_last ? S_IDLE : S_ACTIVE;
    end
  end

  // FSM outputs: which pixel is processed and where it sits; Frame_Start forces (0,0)
  always_comb begin
    w_process  = i_data_in_valid && (i_frame_start || (r_state == S_ACTIVE));
    w_col      = i_frame_start ? '0 : r_col;
    w_row      = i_frame_start ? '0 : r_row;
    w_col_last = (w_col == XW'(IMG_W - 1));
    w_last     = w_process && w_col_last && (w_row == YW'(IMG_H - 1));
    w_win_ok   = w_process && (w_col >= XW'(2)) && (w_row >= YW'(2));
  end

  // Column/row counters advance once per processed pixel and wrap at frame end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_process) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_last ? '0 : (w_row + YW'(1));
      end else begin
        r_col <= w_col + XW'(1);
        r_row <= w_row;
      end
    end
  end

  assign w_line1_out = r_line1[IMG_W-1];
  assign w_line2_out = r_line2[IMG_W-1];

  // Two row delay lines; contents need no reset since validity is gated by row
  always_ff @(posedge i_clk) begin
    if (w_process) begin
      r_line1[0] <= i_data_in;
      r_line2[0] <= w_line1_out;
      for (int i = 1; i < IMG_W; i++) begin
        r_line1[i] <= r_line1[i-1];
        r_line2[i] <= r_line2[i-1];
      end
    end
  end

  // New column top to bottom: two rows up, one row up, current pixel
  always_comb begin
    w_new_col[0] = w_line2_out;
    w_new_col[1] = w_line1_out;
    w_new_col[2] = i_data_in;
  end

  // Window register: new column enters at c=2, older columns slide left
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < 9; k++) begin
        r_win[k] <= '0;
      end
    end else if (w_process) begin
      for (int r = 0; r < 3; r++) begin
        r_win[3*r+0] <= r_win[3*r+1];
        r_win[3*r+1] <= r_win[3*r+2];
        r_win[3*r+2] <= w_new_col[r];
      end
    end
  end

  // Registered status: valid/done are single-cycle, centre holds across stalls
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_window_valid <= 1'b0;
      r_frame_done   <= 1'b0;
      r_center_x     <= '0;
      r_center_y     <= '0;
    end else begin
      r_window_valid <= w_win_ok;
      r_frame_done   <= w_last;
      if (w_process) begin
        r_center_x <= w_col - XW'(1);
        r_center_y <= w_row - YW'(1);
      end
    end
  end

  // Flatten the window, element k at bits [k*DATA_W +: DATA_W]
  always_comb begin
    o_window_out = '0;
    for (int k = 0; k < 9; k++) begin
      o_window_out[k*DATA_W +: DATA_W] = r_win[k];
    end
  end

  assign o_window_valid = r_window_valid;
  assign o_center_x     = r_center_x;
  assign o_center_y     = r_center_y;
  assign o_frame_done   = r_frame_done;

endmodule
